// File: rtl/qoi_decoder_pkg.sv
// Shared QOI decoder types: pixel layout, op/tag codes, FSM states and the index hash.
package qoi_decoder_pkg;

  localparam int unsigned IDX_W     = 6;
  localparam int unsigned IDX_DEPTH = 64;

  typedef logic [IDX_W-1:0] index_t;

  // Packed so that the 32-bit view is [7:0]=r [15:8]=g [23:16]=b [31:24]=a.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  localparam pixel_t PX_RESET = '{a: 8'hFF, b: 8'h00, g: 8'h00, r: 8'h00};

  localparam logic [7:0] QOI_OP_RGB    = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA   = 8'hFF;
  localparam logic [1:0] QOI_TAG_INDEX = 2'b00;
  localparam logic [1:0] QOI_TAG_DIFF  = 2'b01;
  localparam logic [1:0] QOI_TAG_LUMA  = 2'b10;
  localparam logic [1:0] QOI_TAG_RUN   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_ARG,
    ST_RUN,
    ST_DONE
  } state_e;

  // (3r + 5g + 7b + 11a) mod 64; operands truncated first since only the low 6 bits matter.
  function automatic index_t qoi_hash(input pixel_t p);
    return 6'(p.r) * 6'd3 + 6'(p.g) * 6'd5 + 6'(p.b) * 6'd7 + 6'(p.a) * 6'd11;
  endfunction

endpackage

// File: rtl/qoi_decoder_if.sv
// Byte-stream input and pixel-stream output of the QOI decoder.
//  master: environment side (drives bytes, accepts pixels)
//  slave : decoder side (accepts bytes, drives pixels)
interface qoi_decoder_if;
  import qoi_decoder_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  pixel_t     px_o;
  logic       px_valid;
  logic       px_ready;

  modport master (
    output in_data, in_valid, px_ready,
    input  in_ready, px_o, px_valid
  );

  modport slave (
    input  in_data, in_valid, px_ready,
    output in_ready, px_o, px_valid
  );
endinterface

// File: rtl/qoi_decoder_index_table.sv
// 64-entry pixel index table for QOI (shared between decoder and encoder).
//  clk, rst    : clock, synchronous active-high reset (clears all entries)
//  clr_i       : synchronous clear of all entries (new image)
//  we_i        : write wr_px_i at wr_idx_i
//  rd_idx_i    : combinational read address, rd_px_o the entry
module qoi_decoder_index_table
  import qoi_decoder_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr_i,
  input  logic   we_i,
  input  index_t wr_idx_i,
  input  pixel_t wr_px_i,
  input  index_t rd_idx_i,
  output pixel_t rd_px_o
);

  pixel_t tbl_q [IDX_DEPTH];

  // Clear has priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      tbl_q <= '{default: '0};
    end else if (we_i) begin
      tbl_q[wr_idx_i] <= wr_px_i;
    end
  end

  assign rd_px_o = tbl_q[rd_idx_i];

endmodule

// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: consumes QOI op bytes and emits RGBA pixels.
//  clk, rst  : clock, synchronous active-high reset
//  start     : pulse in IDLE latches size and starts a fresh image
//  size      : number of pixels to produce
//  bus       : in_data/in_valid/in_ready byte stream, px_o/px_valid/px_ready pixel stream
//  busy      : decode in progress
//  done      : one-cycle pulse after the last pixel is accepted
//  err       : sticky, a run extended past the end of the image
//  count_o   : pixels accepted by the sink so far
module qoi_decoder
  import qoi_decoder_pkg::*;
#(
  parameter int unsigned SIZE_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  qoi_decoder_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [SIZE_W-1:0] count_o
);

  state_e            state_q, state_d;
  pixel_t            px_q, px_d;
  pixel_t            prev_q, prev_d;
  logic              px_valid_q, px_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [SIZE_W-1:0] count_q, count_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [5:0]        run_q, run_d;
  logic [1:0]        arg_cnt_q, arg_cnt_d;
  logic [7:0]        tag_q, tag_d;
  logic [7:0]        arg_r_q, arg_r_d;
  logic [7:0]        arg_g_q, arg_g_d;
  logic [7:0]        arg_b_q, arg_b_d;

  pixel_t            new_px;
  pixel_t            idx_rd_px;
  logic              emit;
  logic              idx_clr;
  logic              px_acc;
  logic              byte_acc;
  logic              last_pending;
  logic              last_acc;
  logic              in_ready_c;
  logic [1:0]        last_arg;
  logic [7:0]        luma_dg, luma_dr, luma_db;

  // The pending pixel is the final one of the image.
  assign last_pending = px_valid_q && (count_q == size_q - SIZE_W'(1));
  assign px_acc       = px_valid_q && bus.px_ready;
  assign last_acc     = last_pending && bus.px_ready;

  // A byte is taken only when the output register is free (or freeing) and more
  // pixels are still needed, so bytes past the last pixel stay in the stream.
  assign in_ready_c = ((state_q == ST_OP) || (state_q == ST_ARG)) &&
                      (!px_valid_q || (bus.px_ready && !last_pending));
  assign byte_acc   = bus.in_valid && in_ready_c;

  // Index of the byte that completes the op: RGBA=3, RGB=2, LUMA=0.
  assign last_arg = (tag_q == QOI_OP_RGBA) ? 2'd3 :
                    (tag_q == QOI_OP_RGB)  ? 2'd2 : 2'd0;

  assign luma_dg = 8'(tag_q[5:0]) - 8'd32;
  assign luma_dr = luma_dg + 8'(bus.in_data[7:4]) - 8'd8;
  assign luma_db = luma_dg + 8'(bus.in_data[3:0]) - 8'd8;

  qoi_decoder_index_table u_index (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (idx_clr),
    .we_i     (emit),
    .wr_idx_i (qoi_hash(new_px)),
    .wr_px_i  (new_px),
    .rd_idx_i (bus.in_data[5:0]),
    .rd_px_o  (idx_rd_px)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      px_q       <= '0;
      prev_q     <= PX_RESET;
      px_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
      size_q     <= '0;
      run_q      <= '0;
      arg_cnt_q  <= '0;
      tag_q      <= '0;
      arg_r_q    <= '0;
      arg_g_q    <= '0;
      arg_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      prev_q     <= prev_d;
      px_valid_q <= px_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      count_q    <= count_d;
      size_q     <= size_d;
      run_q      <= run_d;
      arg_cnt_q  <= arg_cnt_d;
      tag_q      <= tag_d;
      arg_r_q    <= arg_r_d;
      arg_g_q    <= arg_g_d;
      arg_b_q    <= arg_b_d;
    end
  end

  // Next-state, op decode and pixel formation.
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    prev_d     = prev_q;
    px_valid_d = px_valid_q;
    err_d      = err_q;
    count_d    = count_q;
    size_d     = size_q;
    run_d      = run_q;
    arg_cnt_d  = arg_cnt_q;
    tag_d      = tag_q;
    arg_r_d    = arg_r_q;
    arg_g_d    = arg_g_q;
    arg_b_d    = arg_b_q;
    new_px     = prev_q;
    emit       = 1'b0;
    idx_clr    = 1'b0;

    if (px_acc) begin
      px_valid_d = 1'b0;
      count_d    = count_q + SIZE_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          size_d    = size;
          count_d   = '0;
          err_d     = 1'b0;
          run_d     = '0;
          arg_cnt_d = '0;
          prev_d    = PX_RESET;
          idx_clr   = 1'b1;
          state_d   = (size == '0) ? ST_DONE : ST_OP;
        end
      end

      ST_OP: begin
        if (byte_acc) begin
          if ((bus.in_data == QOI_OP_RGB) || (bus.in_data == QOI_OP_RGBA)) begin
            tag_d     = bus.in_data;
            arg_cnt_d = '0;
            state_d   = ST_ARG;
          end else begin
            case (bus.in_data[7:6])
              QOI_TAG_INDEX: begin
                emit   = 1'b1;
                new_px = idx_rd_px;
              end
              QOI_TAG_DIFF: begin
                emit     = 1'b1;
                new_px.r = prev_q.r + 8'(bus.in_data[5:4]) - 8'd2;
                new_px.g = prev_q.g + 8'(bus.in_data[3:2]) - 8'd2;
                new_px.b = prev_q.b + 8'(bus.in_data[1:0]) - 8'd2;
              end
              QOI_TAG_LUMA: begin
                tag_d     = bus.in_data;
                arg_cnt_d = '0;
                state_d   = ST_ARG;
              end
              default: begin
                // Run: first repeat goes out now, run_q holds the repeats still owed.
                emit   = 1'b1;
                new_px = prev_q;
                run_d  = bus.in_data[5:0];
                if (bus.in_data[5:0] != 6'd0) begin
                  state_d = ST_RUN;
                end
              end
            endcase
          end
        end
      end

      ST_ARG: begin
        if (byte_acc) begin
          if (arg_cnt_q == last_arg) begin
            emit    = 1'b1;
            state_d = ST_OP;
            if (tag_q == QOI_OP_RGBA) begin
              new_px = '{a: bus.in_data, b: arg_b_q, g: arg_g_q, r: arg_r_q};
            end else if (tag_q == QOI_OP_RGB) begin
              new_px = '{a: prev_q.a, b: bus.in_data, g: arg_g_q, r: arg_r_q};
            end else begin
              new_px = '{a: prev_q.a,
                         b: prev_q.b + luma_db,
                         g: prev_q.g + luma_dg,
                         r: prev_q.r + luma_dr};
            end
          end else begin
            arg_cnt_d = arg_cnt_q + 2'd1;
            case (arg_cnt_q)
              2'd0:    arg_r_d = bus.in_data;
              2'd1:    arg_g_d = bus.in_data;
              default: arg_b_d = bus.in_data;
            endcase
          end
        end
      end

      ST_RUN: begin
        if (px_acc && !last_pending) begin
          emit   = 1'b1;
          new_px = prev_q;
          run_d  = run_q - 6'd1;
          if (run_q == 6'd1) begin
            state_d = ST_OP;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (emit) begin
      px_d       = new_px;
      px_valid_d = 1'b1;
      prev_d     = new_px;
    end

    // Final pixel taken: drop any repeats still owed by a run and flag the overflow.
    if (last_acc) begin
      state_d    = ST_DONE;
      px_valid_d = 1'b0;
      run_d      = '0;
      if (state_q == ST_RUN) begin
        err_d = 1'b1;
      end
    end
  end

  assign done_d = (state_d == ST_DONE);

  assign bus.in_ready = in_ready_c;
  assign bus.px_o     = px_q;
  assign bus.px_valid = px_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign count_o      = count_q;

endmodule
